nexys4_display_test_test: RTL and testbench

NEXYS4_DISPLAY_TEST_TEST -- requirements
Module: nexys4_display_test_test

---
 rtl/nexys4_display_test_test.sv | 169 ++++++++++++++++
 tb/tb_nexys4_display_test_test.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/nexys4_display_test_test.sv
// SPI-controlled 8-digit seven-segment display driver for the Nexys4 board.
// Define NEXYS4_DISPLAY_MISO_EN to echo the last accepted frame on spi_miso_o.
module nexys4_display_test_test #(
    parameter int unsigned REFRESH_BITS = 13
) (
    input  logic       block_clk_i,
    input  logic       rst_low_i,
    input  logic       spi_sclk_i,
    input  logic       spi_ss_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic [7:0] segment_o,
    output logic [7:0] digit_o
);
    localparam int unsigned RW = REFRESH_BITS + 3;

    // [1] is the synchronised level, [2] the previous level for edge detection
    logic [2:0]  sclk_sr;
    logic [2:0]  ss_sr;
    logic [1:0]  mosi_sr;
    logic        sclk_rise;
    logic        ss_rise;
    logic        ss_fall;
    logic        shift_en;
    logic [15:0] shift_q;
    logic [15:0] shift_nxt;
    logic [4:0]  count_q;
    logic [4:0]  count_nxt;
    logic        frame_valid_q;
    logic [15:0] frame_q;
    logic [7:0]  ctrl_q;
    logic [7:0]  digit_reg [8];
    logic [RW-1:0] refresh_q;
    logic [2:0]  sel;
    logic [7:0]  cur;
    logic [6:0]  glyph;
    logic        unused_ctrl_bits;

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            sclk_sr <= '1;
            ss_sr   <= '1;
            mosi_sr <= '1;
        end else begin
            sclk_sr <= {sclk_sr[1:0], spi_sclk_i};
            ss_sr   <= {ss_sr[1:0], spi_ss_i};
            mosi_sr <= {mosi_sr[0], spi_mosi_i};
        end
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign ss_rise   = ss_sr[1] & ~ss_sr[2];
    assign ss_fall   = ~ss_sr[1] & ss_sr[2];
    // A bit arriving in the ss-rise cycle still belongs to the closing frame
    assign shift_en  = sclk_rise & (~ss_sr[1] | ss_rise);

    always_comb begin
        shift_nxt = shift_q;
        count_nxt = ss_fall ? '0 : count_q;
        if (shift_en) begin
            shift_nxt = {shift_q[14:0], mosi_sr[1]};
            if (count_nxt != 5'd17)
                count_nxt = count_nxt + 5'd1;
        end
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            shift_q       <= '0;
            count_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_q       <= '0;
        end else begin
            shift_q       <= shift_nxt;
            count_q       <= count_nxt;
            frame_valid_q <= ss_rise && (count_nxt == 5'd16);
            if (ss_rise)
                frame_q <= shift_nxt;
        end
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            ctrl_q <= '0;
            for (int unsigned i = 0; i < 8; i++)
                digit_reg[i] <= '0;
        end else if (frame_valid_q && frame_q[15:12] == 4'h1) begin
            if (frame_q[11:8] == 4'h0)
                ctrl_q <= frame_q[7:0];
            else if (frame_q[11:8] <= 4'h8)
                digit_reg[3'(frame_q[11:8] - 4'h1)] <= frame_q[7:0];
        end
    end

    assign unused_ctrl_bits = ^{ctrl_q[7:4], ctrl_q[1:0]};

    assign sel = refresh_q[RW-1 -: 3];
    assign cur = digit_reg[sel];

    always_comb begin
        glyph = 7'h00;
        case (cur[3:0])
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            refresh_q <= '0;
            digit_o   <= '1;
            segment_o <= '1;
        end else begin
            refresh_q <= refresh_q + RW'(1);
            if (ctrl_q[3]) begin
                digit_o   <= ~(8'd1 << sel);
                segment_o <= ctrl_q[2] ? {~cur[7], ~glyph} : ~cur;
            end else begin
                digit_o   <= '1;
                segment_o <= '1;
            end
        end
    end

`ifdef NEXYS4_DISPLAY_MISO_EN
    logic        sclk_fall;
    logic [15:0] readback_q;
    logic [15:0] tx_q;
    logic        miso_q;

    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];

    // The leading sclk fall precedes the first sample, so shifting waits for a counted bit
    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            readback_q <= '0;
            tx_q       <= '1;
            miso_q     <= 1'b1;
        end else begin
            if (frame_valid_q)
                readback_q <= frame_q;
            if (ss_fall)
                tx_q <= readback_q;
            else if (sclk_fall && !ss_sr[1] && count_q != 5'd0)
                tx_q <= {tx_q[14:0], 1'b1};
            miso_q <= ss_sr[1] ? 1'b1 : tx_q[15];
        end
    end

    assign spi_miso_o = miso_q;
`else
    assign spi_miso_o = 1'b1;
`endif
endmodule

// File: tb/tb_nexys4_display_test_test.sv
// Scoreboard bench for nexys4_display_test_test driving SPI frames and watching the scan.
module tb_nexys4_display_test_test;
    localparam int unsigned RB = 4;
    localparam int unsigned HALF = 6;
    localparam int unsigned SCAN_BOUND = 8 * (1 << RB) + 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b1;
    logic       ss = 1'b1;
    logic       mosi = 1'b1;
    logic       miso;
    logic [7:0] segment;
    logic [7:0] digit;

    int unsigned checks = 0;
    int unsigned failures = 0;

    typedef struct {
        string       tag;
        int unsigned idx;
        logic [7:0]  seg;
    } exp_t;
    exp_t sb[$];

    nexys4_display_test_test #(.REFRESH_BITS(RB)) dut (
        .block_clk_i(clk),
        .rst_low_i  (rst_n),
        .spi_sclk_i (sclk),
        .spi_ss_i   (ss),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .segment_o  (segment),
        .digit_o    (digit)
    );

    always #80 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input int unsigned nbits, input bit hold_ss_high,
                        input bit merge_last, output logic [15:0] rx);
        rx = '1;
        if (!hold_ss_high) ss = 1'b0;
        tick(HALF);
        for (int unsigned i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = v[15 - i];
            tick(HALF);
            rx[15 - i] = miso;
            sclk = 1'b1;
            if (merge_last && i == nbits - 1) ss = 1'b1;
            tick(HALF);
        end
        mosi = 1'b1;
        ss = 1'b1;
        tick(12);
    endtask

    task automatic push(input string tag, input int unsigned idx, input logic [7:0] seg);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.seg = seg;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [7:0] tgt;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tgt = ~(8'd1 << e.idx);
            @(negedge clk);
            for (int unsigned c = 0; c < SCAN_BOUND && digit !== tgt; c++)
                @(negedge clk);
            check_eq({e.tag, "_anode"}, {8'h00, digit}, {8'h00, tgt});
            check_eq({e.tag, "_seg"}, {8'h00, segment}, {8'h00, e.seg});
        end
    endtask

    initial begin
        logic [15:0] rx;
        logic [7:0]  prev;
        int unsigned cnt;

        tick(3);
        check_eq("rst_digit", {8'h00, digit}, 16'h00FF);
        check_eq("rst_seg", {8'h00, segment}, 16'h00FF);
        check_eq("rst_miso", {15'h0, miso}, 16'h0001);
        rst_n = 1'b1;
        tick(2);
        check_eq("post_rst_digit", {8'h00, digit}, 16'h00FF);
        check_eq("post_rst_seg", {8'h00, segment}, 16'h00FF);

        // enable, hex mode, then measure the scan cadence
        send(16'h100C, 16, 1'b0, 1'b0, rx);
        @(negedge clk);
        for (int unsigned c = 0; c < SCAN_BOUND && digit !== 8'hFE; c++)
            @(negedge clk);
        check_eq("scan_start", {8'h00, digit}, 16'h00FE);
        for (int unsigned k = 1; k < 8; k++) begin
            prev = digit;
            cnt = 0;
            while (digit === prev && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            check_eq("scan_period", 16'(cnt), 16'(1 << RB));
            check_eq("scan_anode", {8'h00, digit}, {8'h00, ~(8'd1 << k)});
        end

        send(16'h11AA, 16, 1'b0, 1'b0, rx);
        send(16'h12BB, 16, 1'b0, 1'b0, rx);
        send(16'h13CC, 16, 1'b0, 1'b0, rx);
        send(16'h14DD, 16, 1'b0, 1'b0, rx);
        push("d0_A", 0, 8'h08);
        push("d1_B", 1, 8'h03);
        push("d2_C", 2, 8'h46);
        push("d3_D", 3, 8'h21);
        for (int unsigned i = 4; i < 8; i++) push("dx_0", i, 8'hC0);
        drain();

        send(16'h04FF, 16, 1'b0, 1'b0, rx);
        send(16'hFF77, 16, 1'b0, 1'b0, rx);
        send(16'h1977, 16, 1'b0, 1'b0, rx);
        push("nocmd_d3", 3, 8'h21);
        push("badcmd_d6", 6, 8'hC0);
        push("addr9_d7", 7, 8'hC0);
        drain();

        send(16'h11EE, 16, 1'b1, 1'b0, rx);
        send(16'h11EE, 15, 1'b0, 1'b0, rx);
        push("ss_high_d0", 0, 8'h08);
        drain();

        // last sclk rise and ss rise arrive together; frame must still count 16 bits
        send(16'h1533, 16, 1'b0, 1'b1, rx);
        push("merge_d4", 4, 8'hB0);
        drain();

        send(16'h1008, 16, 1'b0, 1'b0, rx);
        push("raw_d0", 0, 8'h55);
        push("raw_d4", 4, 8'hCC);
        drain();

        send(16'h1000, 16, 1'b0, 1'b0, rx);
        tick(SCAN_BOUND);
        check_eq("off_digit", {8'h00, digit}, 16'h00FF);
        check_eq("off_seg", {8'h00, segment}, 16'h00FF);

        send(16'h12BB, 16, 1'b0, 1'b0, rx);
        send(16'h0000, 16, 1'b0, 1'b0, rx);
`ifdef NEXYS4_DISPLAY_MISO_EN
        check_eq("miso_readback", rx, 16'h12BB);
`else
        check_eq("miso_tied", rx, 16'hFFFF);
`endif
        check_eq("miso_idle", {15'h0, miso}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
